mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified instruction/data memory between the fetch stage (I-side) and the memory stage (D-side) of the pipelined CPU.
- Sequences each access as issue → wait → respond, and returns data with a one-cycle ready pulse.
- Drives stall requests back to the pipeline control.
- Honours the CPU halt signal by blocking new instruction fetches.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data width in bits.
- LAT, 2, memory read latency in cycles, measured from the m_en cycle to the m_rdata-valid cycle. Legal range is 1 to 7.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- hlt  in  1  CPU halted; no new I-side grants while high.
- i_req  in  1  fetch request; held high until i_rdy.
- i_addr  in  AW  fetch address.
- i_rdy  out  1  one-cycle pulse: fetch complete, i_data valid.
- i_data  out  DW  fetched word; held until the next I-side completion.
- d_re  in  1  data load request; held until d_rdy.
- d_we  in  1  data store request; held until d_rdy. d_re and d_we are never both high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdy  out  1  one-cycle pulse: load or store complete.
- d_rdata  out  DW  load data; held until the next D-side load completion.
- stall_if  out  1  combinational: i_req & ~i_rdy & (state!=IDLE | d_re | d_we | hlt) … simplified to i_req & ~i_rdy.
- stall_mem  out  1  combinational: (d_re|d_we) & ~d_rdy.
- busy  out  1  high in every state except IDLE.
- m_en  out  1  memory command strobe; registered; high for exactly one cycle per access.
- m_we  out  1  memory write enable; registered; valid with m_en.
- m_addr  out  AW  memory address; registered.
- m_wdata  out  DW  memory write data; registered.
- m_rdata  in  DW  memory read data; valid exactly LAT cycles after the m_en cycle.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE and the latency counter goes to 0.
  - m_en, m_we, i_rdy, d_rdy, busy are 0. m_addr, m_wdata, i_data, d_rdata are 0.
  - Reset mid-access drops the transaction; any later m_rdata is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
  - IDLE to ISSUE: when (d_re|d_we) is high, or when (i_req & ~hlt) is high.
  - Grant: D-side wins over I-side, because D-side holds the older instruction. The owner (I or D) is latched.
  - Entering ISSUE: m_en=1, m_we=d_we (0 for I-side), and m_addr/m_wdata are loaded from the owner.
  - ISSUE to WAIT: unconditional; m_en/m_we drop to 0; the counter loads LAT-1.
  - WAIT: the counter decrements each cycle. When it is 0 (the m_rdata-valid cycle), m_rdata is captured into the owner's data register (I-side, or D-side loads only) and the state goes to DONE.
  - DONE: the owner's rdy is 1 for this one cycle. New requests are not sampled in this cycle. Next state is IDLE.
- Latency: with a request high in cycle 0 while IDLE:
  - m_en is high in cycle 1.
  - m_rdata is valid in cycle 1+LAT.
  - rdy is high in cycle 2+LAT.
  - The next grant is possible in cycle 3+LAT.
- Stores use the same timing; m_rdata is ignored and d_rdata is unchanged.
- Simultaneous I and D requests: D first; I waits one full transaction, with stall_if held high throughout.
- hlt rising while an I-access is in flight: that access completes normally. Afterwards I-side requests are ignored; D-side requests are still served.
- Requests changing while not in IDLE are ignored. Only the values latched at grant are used.
- No starvation guard is required: D requests are at most one per instruction.

Decomposition:
- Shared header cpu_defines.vh holds:
  - the state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_DONE=2'd3;
  - owner encodings OWN_I=1'b0, OWN_D=1'b1;
  - default AW/DW.
- A sub-module is not warranted. The counter is a 3-bit down-counter inside the module.

Test Plan:
- LAT=2, i_req=1, i_addr=16'h0004, memory model returns 16'hA1B2: m_en high in cycle 1 with m_addr=0004; i_rdy high only in cycle 4; i_data=A1B2; stall_if high in cycles 0–3.
- Same cycle i_req (addr 0010) and d_re (addr 0020): first m_en carries 0020; d_rdy in cycle 4; second m_en carries 0010 in cycle 6; i_rdy in cycle 9.
- d_we=1, d_addr=0030, d_wdata=BEEF: m_en=m_we=1 for one cycle with those values; d_rdy in cycle 4; d_rdata unchanged; read of 0030 afterwards returns BEEF.
- hlt=1 with i_req=1 held for 20 cycles: m_en never asserts and busy stays 0. Then d_re=1 is served normally.
- rst_n=0 during WAIT of a load: the next cycle is IDLE with all outputs 0. The stale m_rdata arriving later does not change d_rdata and no rdy pulse occurs.
- LAT=1 sweep, 8 back-to-back fetches: one i_rdy every 4 cycles; data matches the memory model for every address.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified I/D memory port arbiter.
// State and owner encodings plus default bus widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  // Counter preload so that it reaches zero in the m_rdata-valid cycle.
  function automatic logic [2:0] lat_load(input int lat);
    return 3'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port fixed-latency memory between fetch (I) and memory (D) stages.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE; D-side wins simultaneous requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hlt,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rdy,
  output logic [DW-1:0] i_data,
  input  logic          d_re,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_rdy,
  output logic [DW-1:0] d_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          busy,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  arb_state_e    state_q, state_d;
  arb_owner_e    own_q, own_d;
  logic          is_wr_q, is_wr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_data_q, i_data_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_rdy_q, i_rdy_d;
  logic          d_rdy_q, d_rdy_d;
  logic          busy_q, busy_d;

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_rdy_d   = 1'b0;
    d_rdy_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // D-side holds the older instruction, so it is granted first.
        if (d_re || d_we) begin
          state_d   = ARB_ISSUE;
          own_d     = OWN_D;
          is_wr_d   = d_we;
          m_en_d    = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (i_req && !hlt) begin
          state_d   = ARB_ISSUE;
          own_d     = OWN_I;
          is_wr_d   = 1'b0;
          m_en_d    = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = {DW{1'b0}};
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        cnt_d   = lat_load(LAT);
      end
      ARB_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ARB_DONE;
          if (own_q == OWN_I) begin
            i_data_d = m_rdata;
            i_rdy_d  = 1'b1;
          end else begin
            d_rdy_d = 1'b1;
            if (!is_wr_q) begin
              d_rdata_d = m_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      own_q     <= OWN_I;
      is_wr_q   <= 1'b0;
      cnt_q     <= 3'd0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= {AW{1'b0}};
      m_wdata_q <= {DW{1'b0}};
      i_data_q  <= {DW{1'b0}};
      d_rdata_q <= {DW{1'b0}};
      i_rdy_q   <= 1'b0;
      d_rdy_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_rdy_q   <= i_rdy_d;
      d_rdy_q   <= d_rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdy     = i_rdy_q;
  assign d_rdy     = d_rdy_q;
  assign busy      = busy_q;
  assign stall_if  = i_req & ~i_rdy_q;
  assign stall_mem = (d_re | d_we) & ~d_rdy_q;

endmodule
